// File: rtl/transaction_scheduler_pkg.sv
// Shared definitions for the transaction layer: FSM encodings, word field
// positions and default thresholds.
package transaction_defs;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } sched_state_t;

    localparam int unsigned CLASS_MSB = 11;
    localparam int unsigned CLASS_LSB = 10;
    localparam int unsigned DEST_MSB  = 9;
    localparam int unsigned DEST_LSB  = 8;
    localparam int unsigned DATA_MSB  = 7;
    localparam int unsigned DATA_LSB  = 0;

    localparam int unsigned NUM_FIFOS             = 4;
    localparam int unsigned DEF_EMPTY_THRESHOLD   = 1;
    // The default almost-full threshold is MEM_SIZE-1 and is derived in the top level.

endpackage

// File: rtl/transaction_scheduler_arbiter.sv
// Fixed-priority arbiter over four requesters; the lowest index wins.
module priority_arbiter_4 (
    input  logic [3:0] eligible,
    output logic [3:0] grant,
    output logic       valid
);

    // Isolates the lowest set bit of the eligible vector.
    assign grant = eligible & (~eligible + 4'd1);
    assign valid = |eligible;

endmodule

// File: rtl/transaction_scheduler.sv
// Transaction layer controller: RESET/INIT/IDLE/ACTIVE FSM, threshold latches,
// and fixed-priority routing of the input FIFO heads onto the output FIFOs.
module transaction_scheduler
    import transaction_defs::*;
#(
    parameter int WORD_SIZE = 12,
    parameter int MEM_SIZE  = 8,
    parameter int PTR       = 3,
    parameter int INDEX     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic [PTR-1:0]         full_threshold_in,
    input  logic [PTR-1:0]         empty_threshold_in,
    input  logic [3:0]             in_empty,
    input  logic [4*WORD_SIZE-1:0] in_data,
    input  logic [3:0]             out_almost_full,
    input  logic [3:0]             out_full,
    output logic [3:0]             in_pop,
    output logic [3:0]             out_push,
    output logic [WORD_SIZE-1:0]   data_out,
    output logic [PTR-1:0]         full_threshold,
    output logic [PTR-1:0]         empty_threshold,
    output logic [1:0]             state,
    output logic                   idle
);

    sched_state_t         st, st_nxt;
    logic [INDEX-1:0]     dest [4];
    logic [3:0]           eligible;
    logic [3:0]           grant;
    logic                 grant_valid;
    logic [WORD_SIZE-1:0] grant_word;
    logic                 pop_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= ST_RESET;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_RESET: st_nxt = ST_INIT;
            ST_INIT: begin
                if (!init) st_nxt = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (init)                 st_nxt = ST_INIT;
                else if (in_empty != '1)  st_nxt = ST_ACTIVE;
                else                      st_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_threshold  <= PTR'(MEM_SIZE - 1);
            empty_threshold <= PTR'(DEF_EMPTY_THRESHOLD);
        end else if (st == ST_INIT) begin
            full_threshold  <= full_threshold_in;
            empty_threshold <= empty_threshold_in;
        end
    end

    // A head is eligible only if its destination can accept one more word
    // on top of any push already in flight.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            dest[i]     = in_data[i*WORD_SIZE + DEST_LSB +: INDEX];
            eligible[i] = ~in_empty[i] & ~out_almost_full[dest[i]] & ~out_full[dest[i]];
        end
    end

    priority_arbiter_4 u_arb (
        .eligible (eligible),
        .grant    (grant),
        .valid    (grant_valid)
    );

    always_comb begin
        grant_word = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (grant[i]) grant_word = in_data[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    assign pop_en = (st == ST_ACTIVE) && !init;
    assign in_pop = pop_en ? grant : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_push <= '0;
            data_out <= '0;
        end else if (pop_en && grant_valid) begin
            out_push <= 4'b0001 << grant_word[DEST_MSB:DEST_LSB];
            data_out <= grant_word;
        end else begin
            out_push <= '0;
        end
    end

    assign state = st;
    assign idle  = (st == ST_IDLE) && (out_push == '0);

endmodule

// File: doc/transaction_scheduler.md
# transaction_scheduler

Central controller of the transaction layer. It runs the layer's RESET/INIT/IDLE/ACTIVE state machine and latches the almost-full/almost-empty thresholds during INIT. It arbitrates the four input FIFOs (P0–P3, fixed priority) onto the four output FIFOs (S0–S3), routing each word by its destination field. It sits between the input FIFO bank and the output FIFO bank and drives both banks' pop/push strobes.

## Interface
Parameters:
- WORD_SIZE, 12, word width; [11:10] class, [9:8] destination, [7:0] data
- MEM_SIZE, 8, depth of each FIFO
- PTR, 3, threshold width (log2 MEM_SIZE)
- INDEX, 2, destination field width (log2 of 4 FIFOs)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- init  in  1  request INIT state (threshold programming)
- full_threshold_in  in  PTR  almost-full threshold to latch
- empty_threshold_in  in  PTR  almost-empty threshold to latch
- in_empty  in  4  input FIFO empty flags, bit i = Pi
- in_data  in  4*WORD_SIZE  head words; Pi in bits [i*WORD_SIZE +: WORD_SIZE]; FIFOs are first-word-fall-through
- out_almost_full  in  4  output FIFO almost-full flags, bit d = Sd
- out_full  in  4  output FIFO full flags
- in_pop  out  4  one-hot pop to the input FIFOs (combinational)
- out_push  out  4  one-hot push to the output FIFOs (registered)
- data_out  out  WORD_SIZE  word presented with out_push (registered)
- full_threshold  out  PTR  latched almost-full threshold
- empty_threshold  out  PTR  latched almost-empty threshold
- state  out  2  RESET=0, INIT=1, IDLE=2, ACTIVE=3
- idle  out  1  state==IDLE and no push in flight

## Operation
- Reset (reset=0, async) forces the following values:
  - state=RESET, out_push=0, data_out=0, in_pop=0, idle=0.
  - full_threshold=MEM_SIZE-1, empty_threshold=1.
- State transitions:
  - RESET→INIT on the first edge after reset is released.
  - INIT: latch both thresholds at every edge. INIT→IDLE when init=0.
  - IDLE→ACTIVE when in_empty≠4'b1111.
  - ACTIVE→IDLE when in_empty=4'b1111.
  - IDLE or ACTIVE→INIT when init=1. This takes priority over every other transition.
- Thresholds are constant outside INIT.
- Eligibility: Pi is eligible when in_empty[i]=0, and out_almost_full[d] and out_full[d] are both 0, where d = in_data_Pi[9:8].
- Grant: the lowest-index eligible Pi. Strict priority P0>P1>P2>P3. A blocked higher-priority input does not block lower-priority inputs to other destinations.
- in_pop[i]=1 only when all three hold: state==ACTIVE, init==0, and i is granted. At most one bit is set.
- Class bits [11:10] are carried through unchanged and do not affect arbitration.
- The word is never modified.

## Timing
- A pop in cycle t produces out_push[d]=1 and data_out=word in cycle t+1. Latency is 1, throughput is 1 word/cycle.
- out_push is zero in any cycle that follows a cycle with no grant. data_out holds its last value.
- One word may be in flight when almost-full rises. Required constraint: latched full_threshold ≤ MEM_SIZE-1. No output FIFO can then overflow.
- Back-to-back words to the same destination are allowed.
- init asserted during ACTIVE:
  - in_pop=0 in the same cycle.
  - An already-issued push still completes in the next cycle.
- Last word popped at t: the push occurs at t+1 and state returns to IDLE at t+2. idle=1 only from the cycle after the final push.
- Reset asserted mid-transfer discards the in-flight word immediately (out_push=0, no glitch after release).

## Structure
- Shared package/header transaction_defs holds:
  - state encodings
  - field positions CLASS [11:10], DEST [9:8], DATA [7:0]
  - default thresholds
- Sub-module priority_arbiter_4: combinational fixed-priority grant from a 4-bit eligible vector. One-hot grant plus a valid flag.
- The top level contains the FSM, threshold registers, destination decode, and the output register stage.

## Test plan
- Reset/init sequence:
  - Stimulus: reset=0, then release; hold init=1 for 2 cycles with thresholds (6,2) then (7,1); drop init.
  - Response: state 0→1→1→2; latched thresholds 7/1; no pops.
- Routing:
  - Stimulus: P0..P3 heads 12'h0F5, 12'h5AD, 12'hACA, 12'hF33 (dest 0,1,2,3), all non-empty.
  - Response: pops P0,P1,P2,P3 on consecutive ACTIVE cycles; out_push 0001,0010,0100,1000 one cycle later with matching data_out.
- Priority skip:
  - Stimulus: out_almost_full=4'b0001; P0 head dest 0; P1 head 12'h5AD.
  - Response: P1 popped first; P0 popped in the cycle after almost_full[0] falls.
- Overflow guard:
  - Stimulus: 8 words P0→S0, threshold 7, no output pops.
  - Response: at most 8 pushes to S0; out_full never seen with out_push[0]=1 in the following cycle.
- Init mid-traffic:
  - Stimulus: init=1 while ACTIVE with words queued.
  - Response: in_pop=0 the same cycle; one pending push completes; state=INIT next cycle.
- Async reset mid-traffic:
  - Stimulus: reset=0 between clock edges during a push.
  - Response: out_push, data_out, and state go to 0 immediately.
